vga_pattern_engine: RTL and testbench

//  Parametrised VGA timing + animated pattern source; successor to the fixed 640x480 demo core.

---
 rtl/vga_pattern_engine.sv | 172 +++++++++++++++++
 tb/tb_vga_pattern_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_engine
// Summary  : Parametrised VGA timing generator with an animated pattern source.
//            Optional macro VGA_DITHER_EN adds 2x2 ordered dither before truncation.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_engine #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int COLOR_BITS = 2,
    parameter int SPEED_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode_in,
    input  logic [SPEED_W-1:0]    speed_in,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_on,
    output logic [9:0]            hpos,
    output logic [9:0]            vpos,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  frame_tick
);

    localparam logic [9:0] c_H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] c_HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] c_VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam int         c_DROP     = 4 - COLOR_BITS;

    logic [9:0]         r_hc;
    logic [9:0]         r_vc;
    logic [9:0]         r_anim;
    logic [1:0]         r_mode_sh;
    logic [SPEED_W-1:0] r_speed_sh;

    logic       w_last;
    logic       w_display;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic [9:0] w_s;
    logic [3:0] w_bar;
    logic       w_chk;
    logic [3:0] w_r4, w_g4, w_b4;
    logic [3:0] w_rd, w_gd, w_bd;
    logic       w_unused;

    assign w_last    = (r_hc == c_H_LAST) && (r_vc == c_V_LAST);
    assign w_display = (r_hc < c_H_DISP) && (r_vc < c_V_DISP);
    assign w_hsync_n = !((r_hc >= c_HS_FIRST) && (r_hc <= c_HS_LAST));
    assign w_vsync_n = !((r_vc >= c_VS_FIRST) && (r_vc <= c_VS_LAST));

    assign w_s   = r_hc * r_hc + r_vc * r_vc + r_anim;
    assign w_bar = r_hc[9:6] + r_anim[9:6];
    assign w_chk = r_hc[5] ^ r_vc[5] ^ r_anim[5];

    always_comb begin
        w_r4 = 4'h0;
        w_g4 = 4'h0;
        w_b4 = 4'h0;
        case (r_mode_sh)
            2'd0: begin
                w_r4 = w_s[7:4];
                w_g4 = w_s[8:5];
                w_b4 = w_s[9:6];
            end
            2'd1: begin
                w_r4 = w_bar;
                w_g4 = ~w_bar;
                w_b4 = r_vc[8:5];
            end
            2'd2: begin
                w_r4 = {4{w_chk}};
                w_g4 = {4{w_chk}};
                w_b4 = {4{w_chk}};
            end
            default: begin
                w_r4 = r_anim[9:6];
                w_g4 = r_anim[8:5];
                w_b4 = r_anim[7:4];
            end
        endcase
    end

`ifdef VGA_DITHER_EN
    logic [1:0] w_bayer;
    logic [2:0] w_thr;

    // Threshold is scaled to the number of bits truncation will discard
    assign w_bayer = {r_hc[0] ^ r_vc[0], r_vc[0]};
    generate
        if (c_DROP == 3) begin : g_thr_d3
            assign w_thr = {w_bayer, 1'b0};
        end else begin : g_thr_d012
            assign w_thr = {1'b0, w_bayer >> (2 - c_DROP)};
        end
    endgenerate

    function automatic logic [3:0] f_sat_add(input logic [3:0] c, input logic [2:0] t);
        logic [4:0] sum;
        sum = {1'b0, c} + {2'b00, t};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

    assign w_rd = f_sat_add(w_r4, w_thr);
    assign w_gd = f_sat_add(w_g4, w_thr);
    assign w_bd = f_sat_add(w_b4, w_thr);
`else
    assign w_rd = w_r4;
    assign w_gd = w_g4;
    assign w_bd = w_b4;
`endif

    assign w_unused = &{1'b0, w_s[3:0], w_rd, w_gd, w_bd};

    // Mode and speed are only sampled on the last pixel so a frame never mixes patterns
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hc       <= '0;
            r_vc       <= '0;
            r_anim     <= '0;
            r_mode_sh  <= '0;
            r_speed_sh <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b0;
            hpos       <= '0;
            vpos       <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (r_hc == c_H_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == c_V_LAST) ? 10'd0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 10'd1;
            end
            if (w_last) begin
                r_anim     <= r_anim + 10'(r_speed_sh);
                r_mode_sh  <= mode_in;
                r_speed_sh <= speed_in;
            end
            hsync      <= w_hsync_n;
            vsync      <= w_vsync_n;
            display_on <= w_display;
            hpos       <= r_hc;
            vpos       <= r_vc;
            red        <= w_display ? w_rd[3 -: COLOR_BITS] : '0;
            green      <= w_display ? w_gd[3 -: COLOR_BITS] : '0;
            blue       <= w_display ? w_bd[3 -: COLOR_BITS] : '0;
            frame_tick <= w_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_engine
// Summary  : Scoreboard bench for vga_pattern_engine on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_engine;

    localparam int HD = 34, HF = 2, HSW = 3, HB = 1;
    localparam int VD = 34, VF = 1, VSW = 2, VB = 1;
    localparam int CB = 2, SW = 4;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VT = VD + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int OW = 3 + 20 + 3 * CB + 1;
    localparam logic [OW-1:0] c_RST_EXP = {2'b11, {(OW-2){1'b0}}};

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode_in;
    logic [SW-1:0] speed_in;
    logic          hsync, vsync, display_on, frame_tick;
    logic [9:0]    hpos, vpos;
    logic [CB-1:0] red, green, blue;
    logic [OW-1:0] w_obs;

    vga_pattern_engine #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .COLOR_BITS(CB), .SPEED_W(SW)
    ) u_dut (
        .clk(clk), .reset(reset), .mode_in(mode_in), .speed_in(speed_in),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .red(red), .green(green), .blue(blue),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    assign w_obs = {hsync, vsync, display_on, hpos, vpos, red, green, blue, frame_tick};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

`ifdef VGA_DITHER_EN
    function automatic int dith(input int c, input int x, input int y);
        int k, t, d;
        d = 4 - CB;
        k = ((x % 2) == 0) ? (((y % 2) == 0) ? 0 : 3) : (((y % 2) == 0) ? 2 : 1);
        t = (d <= 2) ? (k >> (2 - d)) : (k << 1);
        return (c + t > 15) ? 15 : c + t;
    endfunction
`endif

    function automatic logic [OW-1:0] model_pix(input int x, input int y, input int md, input int an);
        int s, rr, gg, bb;
        logic hs, vs, de, ft;
        logic [3:0] r4, g4, b4;
        logic [CB-1:0] r, g, b;
        s = (x * x + y * y + an) % 1024;
        case (md)
            0: begin rr = (s >> 4) & 15; gg = (s >> 5) & 15; bb = (s >> 6) & 15; end
            1: begin rr = ((x >> 6) + (an >> 6)) & 15; gg = 15 - rr; bb = (y >> 5) & 15; end
            2: begin rr = (((x >> 5) ^ (y >> 5) ^ (an >> 5)) & 1) * 15; gg = rr; bb = rr; end
            default: begin rr = (an >> 6) & 15; gg = (an >> 5) & 15; bb = (an >> 4) & 15; end
        endcase
`ifdef VGA_DITHER_EN
        rr = dith(rr, x, y);
        gg = dith(gg, x, y);
        bb = dith(bb, x, y);
`endif
        r4 = 4'(rr);
        g4 = 4'(gg);
        b4 = 4'(bb);
        r = r4[3 -: CB];
        g = g4[3 -: CB];
        b = b4[3 -: CB];
        de = (x < HD) && (y < VD);
        if (!de) begin
            r = '0;
            g = '0;
            b = '0;
        end
        hs = !((x >= HD + HF) && (x < HD + HF + HSW));
        vs = !((y >= VD + VF) && (y < VD + VF + VSW));
        ft = (x == HT - 1) && (y == VT - 1);
        return {hs, vs, de, 10'(x), 10'(y), r, g, b, ft};
    endfunction

    // Reference raster: expected output pushed at each edge, compared half a cycle later
    logic [OW-1:0] sb_q[$];
    int m_hc = 0, m_vc = 0, m_anim = 0, m_mode = 0, m_speed = 0;

    always @(posedge clk) begin
        if (reset) begin
            sb_q.push_back(c_RST_EXP);
            m_hc    <= 0;
            m_vc    <= 0;
            m_anim  <= 0;
            m_mode  <= 0;
            m_speed <= 0;
        end else begin
            sb_q.push_back(model_pix(m_hc, m_vc, m_mode, m_anim));
            if (m_hc == HT - 1 && m_vc == VT - 1) begin
                m_anim  <= (m_anim + m_speed) % 1024;
                m_mode  <= int'(mode_in);
                m_speed <= int'(speed_in);
            end
            if (m_hc == HT - 1) begin
                m_hc <= 0;
                m_vc <= (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc <= m_hc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) check_val("pix", w_obs, sb_q.pop_front());
    end

    task automatic wait_pix(input int x, input int y);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (hpos == 10'(x) && vpos == 10'(y)) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("wait_pix", ok, 1);
    endtask

    task automatic wait_tick();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("wait_tick", ok, 1);
    endtask

    function automatic logic cur_sync(input logic vert);
        return vert ? vsync : hsync;
    endfunction

    task automatic measure_sync(input string tag, input logic vert, input int start_pos,
                                input int low_len, input int period);
        logic ok, prev;
        int cnt, per;
        ok = 1'b0;
        prev = cur_sync(vert);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (prev && !cur_sync(vert)) begin
                ok = 1'b1;
                break;
            end
            prev = cur_sync(vert);
        end
        check_val({tag, "_fall"}, ok, 1);
        check_val({tag, "_start"}, vert ? vpos : hpos, start_pos);
        cnt = 1;
        while (!cur_sync(vert) && cnt < 2 * FRAME) begin
            @(negedge clk);
            if (!cur_sync(vert)) cnt++;
        end
        check_val({tag, "_width"}, cnt, low_len);
        per = cnt + 1;
        prev = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (prev && !cur_sync(vert)) break;
            per++;
            prev = cur_sync(vert);
        end
        check_val({tag, "_period"}, per, period);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_hold", {hsync, vsync, display_on, red, green, blue},
                      {3'b110, {(3 * CB){1'b0}}});
        end
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_release", {hpos, vpos, display_on}, {20'd0, 1'b1});
    endtask

    int  per;
    logic ok;

    initial begin
        reset = 1'b1;
        mode_in = 2'd2;
        speed_in = '0;
        reset_pulse();

        measure_sync("hs", 1'b0, HD + HF, HSW, HT);
        measure_sync("vs", 1'b1, VD + VF, VSW * HT, FRAME);

        wait_tick();
        per = 0;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            per++;
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("tick_seen", ok, 1);
        check_val("tick_period", per, FRAME);

        // Checkerboard with anim still 0
        wait_pix(0, 0);
        check_val("chk_0_0", {red, green, blue}, 6'h00);
        wait_pix(32, 0);
        check_val("chk_32_0", {red, green, blue}, 6'h3F);
        wait_pix(32, 32);
        check_val("chk_32_32", {red, green, blue}, 6'h00);

        mode_in = 2'd0;
        speed_in = 4'd7;
        repeat (2) wait_tick();
        wait_pix(0, 10);
        mode_in = 2'd2;
        speed_in = 4'd3;
        repeat (2) wait_tick();
        mode_in = 2'd1;
        speed_in = 4'd15;
        repeat (3) wait_tick();
        mode_in = 2'd3;
        repeat (20) wait_tick();
        speed_in = 4'd0;
        repeat (2) wait_tick();

        wait_pix(5, 20);
        reset_pulse();
        mode_in = 2'd0;
        speed_in = 4'd5;
        repeat (2) wait_tick();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
